// File: rtl/lc3b_mem_arbiter_pkg.sv
// Shared types for the LC-3b physical-memory arbiter.
//   lc3b_word / lc3b_block : byte address and cache line
//   lc3b_arb_state         : grant FSM states
//   lc3b_arb_owner         : which cache was granted last
package lc3b_mem_arbiter_pkg;

    localparam int LC3B_ADDR_W = 16;
    localparam int LC3B_LINE_W = 128;

    typedef logic [LC3B_ADDR_W-1:0] lc3b_word;
    typedef logic [LC3B_LINE_W-1:0] lc3b_block;

    typedef enum logic [1:0] {
        arb_idle,
        arb_grant_i,
        arb_grant_d
    } lc3b_arb_state;

    typedef enum logic {
        own_i,
        own_d
    } lc3b_arb_owner;

endpackage

// File: rtl/lc3b_arb_watchdog.sv
// Grant watchdog: counts cycles spent in a grant and flags expiry.
//   clk, reset_n : clock, async active-low reset
//   clear        : restart the count (new grant)
//   enable       : a grant is active this cycle
//   expired      : this is the TIMEOUT-th consecutive grant cycle
module lc3b_arb_watchdog #(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // count holds the number of grant cycles already completed, so the
    // abort fires on the edge that closes grant cycle number TIMEOUT.
    assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/lc3b_mem_arbiter.sv
// Shares the single pmem line port between the I-cache and D-cache.
// One owner at a time, round-robin on collisions, command latched at grant.
//   icache_* : line read requests, rdata/resp back to the I-cache
//   dcache_* : line read/writeback requests, rdata/resp back to the D-cache
//   pmem_*   : registered command to physical memory, rdata/resp from it
//   arb_error: sticky; D read+write together, or watchdog abort
module lc3b_mem_arbiter
    import lc3b_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = LC3B_ADDR_W,
    parameter int LINE_W  = LC3B_LINE_W,
    parameter int TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    output logic              arb_error
);

    lc3b_arb_state     state_q, state_d;
    lc3b_arb_owner     last_grant_q;
    logic [ADDR_W-5:0] line_q;
    logic [LINE_W-1:0] wdata_q, irdata_q, drdata_q;
    logic              read_q, write_q, err_q;
    logic              i_req, d_req, pick_d, grant, busy, wd_expired;
    logic              unused_offset;

    assign i_req = icache_read;
    assign d_req = dcache_read | dcache_write;
    // Lone requester wins; on a collision the side not served last wins.
    assign pick_d = d_req && (!i_req || last_grant_q == own_i);
    assign grant  = (state_q == arb_idle) && (i_req || d_req);
    assign busy   = (state_q != arb_idle);

    generate
        if (TIMEOUT > 0) begin : g_wd
            lc3b_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
                .clk     (clk),
                .reset_n (reset_n),
                .clear   (grant),
                .enable  (busy),
                .expired (wd_expired)
            );
        end else begin : g_no_wd
            assign wd_expired = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            arb_idle:    if (grant) state_d = pick_d ? arb_grant_d : arb_grant_i;
            arb_grant_i,
            arb_grant_d: if (pmem_resp || wd_expired) state_d = arb_idle;
            default:     state_d = arb_idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= arb_idle;
            last_grant_q <= own_i;
            line_q       <= '0;
            wdata_q      <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            err_q        <= 1'b0;
            irdata_q     <= '0;
            drdata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                last_grant_q <= pick_d ? own_d : own_i;
                line_q       <= pick_d ? dcache_address[ADDR_W-1:4]
                                       : icache_address[ADDR_W-1:4];
                if (pick_d) wdata_q <= dcache_wdata;
                // read+write together is served as a writeback
                write_q <= pick_d && dcache_write;
                read_q  <= !(pick_d && dcache_write);
                if (pick_d && dcache_read && dcache_write) err_q <= 1'b1;
            end else if (state_d == arb_idle) begin
                read_q  <= 1'b0;
                write_q <= 1'b0;
            end
            if (busy && !pmem_resp && wd_expired) err_q <= 1'b1;
            if (icache_resp) irdata_q <= pmem_rdata;
            if (dcache_resp) drdata_q <= pmem_rdata;
        end
    end

    // Completion is passed through in the pmem_resp cycle itself.
    assign icache_resp  = (state_q == arb_grant_i) && pmem_resp;
    assign dcache_resp  = (state_q == arb_grant_d) && pmem_resp;
    assign icache_rdata = icache_resp ? pmem_rdata : irdata_q;
    assign dcache_rdata = dcache_resp ? pmem_rdata : drdata_q;

    assign pmem_read    = read_q;
    assign pmem_write   = write_q;
    assign pmem_address = {line_q, 4'b0};
    assign pmem_wdata   = wdata_q;
    assign arb_error    = err_q;

    // Byte offsets within a line never reach pmem.
    assign unused_offset = ^{icache_address[3:0], dcache_address[3:0]};

endmodule

// File: tb/tb_lc3b_mem_arbiter.sv
// Randomized bench for lc3b_mem_arbiter with a transaction-level reference
// model (owner, round-robin memory, sticky error) and directed scenarios.
module tb_lc3b_mem_arbiter;

    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         icache_read = 1'b0, dcache_read = 1'b0, dcache_write = 1'b0;
    logic [15:0]  icache_address = '0, dcache_address = '0;
    logic [127:0] dcache_wdata = '0, pmem_rdata = '0;
    logic         pmem_resp = 1'b0;
    logic [127:0] icache_rdata, dcache_rdata, pmem_wdata;
    logic         icache_resp, dcache_resp, pmem_read, pmem_write, arb_error;
    logic [15:0]  pmem_address;

    lc3b_mem_arbiter #(.ADDR_W(16), .LINE_W(128), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .arb_error(arb_error)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // reference model: 0 = nobody owns pmem, 1 = I-cache, 2 = D-cache
    int           m_own = 0, m_age = 0;
    bit           m_last_d = 0, m_wr = 0, m_err = 0;
    logic [15:0]  m_addr = '0;
    logic [127:0] m_wdata = '0, m_irdata = '0, m_drdata = '0;

    // stimulus knobs and bookkeeping
    bit           rnd_req = 0, spur = 0, hold_resp = 0, force_resp = 0;
    int           fix_lat = 0, lat_cnt = 0, lat_tgt = 1, cmd_cycles = 0;
    bit           i_want = 0, d_want = 0, d_want_rd = 0, d_want_wr = 0;
    logic [15:0]  i_want_addr = '0, d_want_addr = '0;
    logic [127:0] d_want_data = '0;
    bit           i_drop = 0, d_drop = 0, prev_cmd = 0;
    int           i_done = 0, d_done = 0, i_issued = 0, d_issued = 0;
    logic [15:0]  last_addr = '0;
    logic [127:0] last_wdata = '0;
    bit           last_wr = 0;
    logic [15:0]  rise_addr[$];

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        bit ir, dr, gd, cmd;
        @(negedge clk);
        // requesters hold until resp, then drop in the following cycle
        if (i_drop) begin
            icache_read = 1'b0; i_drop = 0;
        end else if (!icache_read) begin
            if (rnd_req && $urandom_range(3) == 0) begin
                i_want = 1; i_want_addr = 16'($urandom);
            end
            if (i_want) begin
                icache_read = 1'b1; icache_address = i_want_addr; i_want = 0; i_issued++;
            end else icache_address = 16'($urandom);
        end
        if (d_drop) begin
            dcache_read = 1'b0; dcache_write = 1'b0; d_drop = 0;
        end else if (!dcache_read && !dcache_write) begin
            if (rnd_req && $urandom_range(3) == 0) begin
                d_want = 1; d_want_addr = 16'($urandom); d_want_data = rnd_line();
                d_want_wr = $urandom_range(1) == 1; d_want_rd = !d_want_wr;
            end
            if (d_want) begin
                dcache_read = d_want_rd; dcache_write = d_want_wr;
                dcache_address = d_want_addr; dcache_wdata = d_want_data;
                d_want = 0; d_issued++;
            end else begin
                dcache_address = 16'($urandom); dcache_wdata = rnd_line();
            end
        end
        // pmem responder
        pmem_resp = 1'b0;
        if (pmem_read || pmem_write) begin
            lat_cnt++;
            if (!hold_resp && lat_cnt >= lat_tgt) begin
                pmem_resp = 1'b1; pmem_rdata = rnd_line();
            end
        end else begin
            lat_cnt = 0;
            lat_tgt = (fix_lat != 0) ? fix_lat : int'($urandom_range(1, 5));
            if (spur && $urandom_range(7) == 0) begin
                pmem_resp = 1'b1; pmem_rdata = rnd_line();
            end
        end
        if (force_resp) begin
            pmem_resp = 1'b1; pmem_rdata = rnd_line();
        end
        #1;
        cmd = pmem_read | pmem_write;
        if (cmd) cmd_cycles++;
        if (cmd && !prev_cmd) begin
            rise_addr.push_back(pmem_address);
            last_addr = pmem_address; last_wr = pmem_write; last_wdata = pmem_wdata;
        end
        prev_cmd = cmd;
        // compare against the model
        chk("pmem_read", pmem_read, m_own != 0 && !m_wr);
        chk("pmem_write", pmem_write, m_own != 0 && m_wr);
        if (m_own != 0) chk("pmem_address", pmem_address, {m_addr[15:4], 4'h0});
        if (m_own != 0 && m_wr) chk("pmem_wdata", pmem_wdata, m_wdata);
        ir = (m_own == 1) && pmem_resp;
        dr = (m_own == 2) && pmem_resp;
        if (ir) m_irdata = pmem_rdata;
        if (dr) m_drdata = pmem_rdata;
        chk("icache_resp", icache_resp, ir);
        chk("dcache_resp", dcache_resp, dr);
        chk("icache_rdata", icache_rdata, m_irdata);
        chk("dcache_rdata", dcache_rdata, m_drdata);
        chk("arb_error", arb_error, m_err);
        if (ir) begin i_done++; i_drop = 1; end
        if (dr) begin d_done++; d_drop = 1; end
        // advance the model across the coming edge
        if (m_own != 0) begin
            m_age++;
            if (pmem_resp) m_own = 0;
            else if (m_age == TMO) begin
                if (m_own == 1) i_drop = 1; else d_drop = 1;  // requester gives up
                m_own = 0; m_err = 1;
            end
        end else if (icache_read || dcache_read || dcache_write) begin
            gd = (dcache_read || dcache_write) && (!icache_read || !m_last_d);
            m_own = gd ? 2 : 1;
            m_last_d = gd;
            m_addr = gd ? dcache_address : icache_address;
            m_wr = gd && dcache_write;
            m_wdata = dcache_wdata;
            m_age = 0;
            if (gd && dcache_read && dcache_write) m_err = 1;
        end
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((icache_read || dcache_read || dcache_write || i_want || d_want ||
                i_drop || d_drop || m_own != 0) && n < maxc) begin
            step(); n++;
        end
        chk("drain_bound", n < maxc, 1'b1);
    endtask

    task automatic zero_checks(input string tag);
        chk({tag, "_pmem_read"}, pmem_read, 1'b0);
        chk({tag, "_pmem_write"}, pmem_write, 1'b0);
        chk({tag, "_pmem_address"}, pmem_address, 16'h0);
        chk({tag, "_pmem_wdata"}, pmem_wdata, 128'h0);
        chk({tag, "_icache_resp"}, icache_resp, 1'b0);
        chk({tag, "_dcache_resp"}, dcache_resp, 1'b0);
        chk({tag, "_icache_rdata"}, icache_rdata, 128'h0);
        chk({tag, "_dcache_rdata"}, dcache_rdata, 128'h0);
        chk({tag, "_arb_error"}, arb_error, 1'b0);
    endtask

    // asserts reset in the middle of a low clock phase, checks, then releases
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #2 reset_n = 1'b0;
        pmem_resp = 1'b0;
        #1 zero_checks(tag);
        icache_read = 1'b0; dcache_read = 1'b0; dcache_write = 1'b0;
        i_want = 0; d_want = 0; i_drop = 0; d_drop = 0; prev_cmd = 0;
        m_own = 0; m_age = 0; m_last_d = 0; m_wr = 0; m_err = 0;
        m_irdata = '0; m_drdata = '0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int i0, d0, n;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1 zero_checks("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // 1: lone I read, resp three cycles after pmem_read rises
        fix_lat = 4; i0 = i_done; d0 = d_done;
        i_want = 1; i_want_addr = 16'h1234;
        drain(30);
        chk("t1_addr", last_addr, 16'h1230);
        chk("t1_iresp_count", i_done - i0, 1);
        chk("t1_dresp_count", d_done - d0, 0);

        // 2: D writeback
        d0 = d_done;
        d_want = 1; d_want_rd = 0; d_want_wr = 1; d_want_addr = 16'h8000;
        d_want_data = {16{8'hA5}};
        drain(30);
        chk("t2_write", last_wr, 1'b1);
        chk("t2_wdata", last_wdata, {16{8'hA5}});
        chk("t2_addr", last_addr, 16'h8000);
        chk("t2_dresp_count", d_done - d0, 1);

        // 3: collisions straight after reset, repeated
        reset_pulse("t3_reset");
        fix_lat = 2;
        rise_addr.delete();
        for (int k = 0; k < 2; k++) begin
            i_want = 1; i_want_addr = 16'h1000;
            d_want = 1; d_want_rd = 1; d_want_wr = 0; d_want_addr = 16'h2000;
            drain(40);
        end
        chk("t3_grants", rise_addr.size(), 4);
        if (rise_addr.size() == 4) begin
            chk("t3_grant0", rise_addr[0], 16'h2000);
            chk("t3_grant1", rise_addr[1], 16'h1000);
            chk("t3_grant2", rise_addr[2], 16'h2000);
            chk("t3_grant3", rise_addr[3], 16'h1000);
        end

        // 4: idle D address moves every cycle while I is granted
        fix_lat = 5;
        i_want = 1; i_want_addr = 16'h456C;
        drain(30);
        chk("t4_addr", last_addr, 16'h4560);

        // random phase with stray pmem_resp pulses while idle
        fix_lat = 0; rnd_req = 1; spur = 1;
        i0 = i_done - i_issued; d0 = d_done - d_issued;
        repeat (600) step();
        rnd_req = 0; spur = 0;
        drain(60);
        chk("rand_i_scoreboard", i_done - i_issued, i0);
        chk("rand_d_scoreboard", d_done - d_issued, d0);

        // 5: reset during GRANT_D, then a late pmem_resp
        fix_lat = 6; d0 = d_done;
        d_want = 1; d_want_rd = 1; d_want_wr = 0; d_want_addr = 16'h9990;
        n = 0;
        while (m_own != 2 && n < 10) begin step(); n++; end
        step(); step();
        chk("t5_in_grant", pmem_read, 1'b1);
        reset_pulse("t5_reset");
        force_resp = 1; step(); force_resp = 0;
        step();
        chk("t5_no_resp", d_done - d0, 0);

        // 6: watchdog abort with pmem silent
        hold_resp = 1; cmd_cycles = 0; i0 = i_done;
        i_want = 1; i_want_addr = 16'h7770;
        drain(40);
        hold_resp = 0;
        chk("t6_cmd_cycles", cmd_cycles, TMO);
        chk("t6_error", arb_error, 1'b1);
        chk("t6_no_resp", i_done - i0, 0);
        repeat (3) step();
        chk("t6_sticky", arb_error, 1'b1);

        // D read+write together is served as a write and flags an error
        reset_pulse("t7_reset");
        fix_lat = 3;
        d_want = 1; d_want_rd = 1; d_want_wr = 1; d_want_addr = 16'h3008;
        d_want_data = rnd_line();
        drain(30);
        chk("t7_write", last_wr, 1'b1);
        chk("t7_error", arb_error, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
